seq_borrow_select_subtractor: RTL and testbench

//   Multi-cycle subtractor (the reverse of the carry-select adder): diff = a - b - bin.

---
 rtl/seq_borrow_select_subtractor_if.sv | 36 +++
 rtl/seq_borrow_select_subtractor.sv | 133 +++++++++++++
 tb/tb_seq_borrow_select_subtractor.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_borrow_select_subtractor_if.sv
// rtl/seq_borrow_select_subtractor_if.sv - handshake/operand bundle for the borrow-select subtractor
//
// Purpose: groups the start/busy/done handshake with the operand and result
//          buses so the datapath controller and the subtractor share one port.
// Signals:
//   start  controller -> subtractor  request, sampled only while idle
//   a, b   controller -> subtractor  minuend / subtrahend (WIDTH bits)
//   bin    controller -> subtractor  borrow-in
//   diff   subtractor -> controller  result (WIDTH bits), held between operations
//   bout   subtractor -> controller  borrow-out (1 = a < b + bin, unsigned)
//   busy   subtractor -> controller  high while slices are being processed
//   done   subtractor -> controller  one-cycle pulse when diff/bout update
// Modports: master (controller side), slave (subtractor side).

interface seq_borrow_select_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, bin,
    input  diff, bout, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, busy, done
  );
endinterface

// File: rtl/seq_borrow_select_subtractor.sv
// rtl/seq_borrow_select_subtractor.sv - multi-cycle borrow-select subtractor, one slice per cycle
//
// Purpose: computes diff = a - b - bin (unsigned, modulo 2^WIDTH) one CHUNK-bit
//          slice per clock, LSB slice first. Each slice evaluates both borrow-in
//          outcomes and the registered borrow picks one.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of seq_borrow_select_subtractor_if
//          (start/a/b/bin in, diff/bout/busy/done out)
// Parameters:
//   WIDTH  operand/result width, multiple of CHUNK
//   CHUNK  slice width processed per cycle

module seq_borrow_select_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  seq_borrow_select_subtractor_if.slave bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] work_q,   work_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             bout_q,   bout_d;

  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK:0]   d0;
  logic [CHUNK:0]   d1;
  logic [CHUNK:0]   sel;
  int               base;

  // Borrow-select slice: both candidates are formed in parallel, the MSB of
  // each CHUNK+1-bit result is that slice's borrow-out.
  always_comb begin
    base    = int'(cnt_q) * CHUNK;
    a_slice = a_q[base +: CHUNK];
    b_slice = b_q[base +: CHUNK];
    d0      = {1'b0, a_slice} - {1'b0, b_slice};
    d1      = d0 - (CHUNK + 1)'(1);
    sel     = borrow_q ? d1 : d0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        work_d[base +: CHUNK] = sel[CHUNK-1:0];
        borrow_d              = sel[CHUNK];
        if (cnt_q == LAST_CNT) begin
          // Publish the full word, including the slice written this cycle,
          // so partial results never reach diff.
          diff_d  = work_d;
          bout_d  = sel[CHUNK];
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        // start is deliberately ignored here; the next request is taken in IDLE.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_borrow_select_subtractor.sv
// tb/tb_seq_borrow_select_subtractor.sv - self-checking bench for seq_borrow_select_subtractor

module tb_seq_borrow_select_subtractor;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_err;

  logic [15:0] last_diff16;
  logic        last_bout16;
  logic [3:0]  last_diff4;
  logic        last_bout4;

  seq_borrow_select_subtractor_if #(.WIDTH(16)) ifc16 ();
  seq_borrow_select_subtractor_if #(.WIDTH(4))  ifc4 ();

  seq_borrow_select_subtractor #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc16.slave)
  );

  seq_borrow_select_subtractor #(.WIDTH(4), .CHUNK(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic, result wraps modulo 2^w, borrow when negative.
  task automatic ref_sub(input int w, input longint a, input longint b, input longint bi,
                         output logic [15:0] d, output logic bo);
    longint r;
    r  = a - b - bi;
    bo = (r < 0);
    r  = r & ((longint'(1) << w) - 1);
    d  = 16'(r);
  endtask

  task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic bi, input string tag);
    logic [15:0] ed;
    logic        eb;
    int          busy_n;
    int          waited;
    ref_sub(16, longint'(a), longint'(b), longint'(bi), ed, eb);
    @(negedge clk);
    ifc16.start = 1'b1;
    ifc16.a     = a;
    ifc16.b     = b;
    ifc16.bin   = bi;
    @(negedge clk);
    ifc16.start = 1'b0;
    ifc16.a     = 16'($urandom);
    ifc16.b     = 16'($urandom);
    ifc16.bin   = 1'($urandom_range(0, 1));
    busy_n = 0;
    waited = 0;
    while (ifc16.done !== 1'b1 && waited < 20) begin
      if (ifc16.busy === 1'b1) busy_n++;
      chk({tag, " diff_hold"}, 32'(ifc16.diff), 32'(last_diff16));
      chk({tag, " bout_hold"}, 32'(ifc16.bout), 32'(last_bout16));
      @(negedge clk);
      waited++;
    end
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'd4);
    chk({tag, " done"}, 32'(ifc16.done), 32'd1);
    chk({tag, " busy_at_done"}, 32'(ifc16.busy), 32'd0);
    chk({tag, " diff"}, 32'(ifc16.diff), 32'(ed));
    chk({tag, " bout"}, 32'(ifc16.bout), 32'(eb));
    @(negedge clk);
    chk({tag, " done_drop"}, 32'(ifc16.done), 32'd0);
    chk({tag, " diff_kept"}, 32'(ifc16.diff), 32'(ed));
    last_diff16 = ed;
    last_bout16 = eb;
  endtask

  task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic bi, input string tag);
    logic [15:0] ed;
    logic        eb;
    ref_sub(4, longint'(a), longint'(b), longint'(bi), ed, eb);
    @(negedge clk);
    ifc4.start = 1'b1;
    ifc4.a     = a;
    ifc4.b     = b;
    ifc4.bin   = bi;
    @(negedge clk);
    ifc4.start = 1'b0;
    ifc4.a     = 4'($urandom);
    ifc4.b     = 4'($urandom);
    chk({tag, " busy"}, 32'(ifc4.busy), 32'd1);
    chk({tag, " diff_hold"}, 32'(ifc4.diff), 32'(last_diff4));
    @(negedge clk);
    chk({tag, " done"}, 32'(ifc4.done), 32'd1);
    chk({tag, " busy_at_done"}, 32'(ifc4.busy), 32'd0);
    chk({tag, " diff"}, 32'(ifc4.diff), 32'(ed[3:0]));
    chk({tag, " bout"}, 32'(ifc4.bout), 32'(eb));
    @(negedge clk);
    chk({tag, " done_drop"}, 32'(ifc4.done), 32'd0);
    last_diff4 = ed[3:0];
    last_bout4 = eb;
  endtask

  initial begin
    int waited;
    int busy_n;
    n_cmp = 0;
    n_err = 0;
    last_diff16 = '0;
    last_bout16 = 1'b0;
    last_diff4  = '0;
    last_bout4  = 1'b0;
    rst_n = 1'b0;
    ifc16.start = 1'b0; ifc16.a = '0; ifc16.b = '0; ifc16.bin = 1'b0;
    ifc4.start  = 1'b0; ifc4.a  = '0; ifc4.b  = '0; ifc4.bin  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst diff16", 32'(ifc16.diff), 32'd0);
    chk("rst bout16", 32'(ifc16.bout), 32'd0);
    chk("rst busy16", 32'(ifc16.busy), 32'd0);
    chk("rst done16", 32'(ifc16.done), 32'd0);
    chk("rst diff4",  32'(ifc4.diff),  32'd0);
    chk("rst done4",  32'(ifc4.done),  32'd0);
    rst_n = 1'b1;

    // Directed 16-bit cases
    do_op16(16'h1234, 16'h0235, 1'b0, "d1234");
    chk("d1234 const", 32'(ifc16.diff), 32'h0FFF);
    do_op16(16'h0000, 16'h0001, 1'b0, "d0000");
    chk("d0000 const", 32'(ifc16.diff), 32'hFFFF);
    do_op16(16'hFFFF, 16'hFFFF, 1'b1, "dFFFF");
    chk("dFFFF bout", 32'(ifc16.bout), 32'd1);
    do_op16(16'h8000, 16'h0000, 1'b1, "d8000");
    chk("d8000 const", 32'(ifc16.diff), 32'h7FFF);

    // Start re-asserted during RUN and DONE must be ignored
    @(negedge clk);
    ifc16.start = 1'b1; ifc16.a = 16'h0010; ifc16.b = 16'h0001; ifc16.bin = 1'b0;
    @(negedge clk);
    ifc16.a = 16'hFFFF; ifc16.b = 16'h1234; ifc16.bin = 1'b1;
    busy_n = 0;
    waited = 0;
    while (ifc16.done !== 1'b1 && waited < 20) begin
      if (ifc16.busy === 1'b1) busy_n++;
      chk("ovl diff_hold", 32'(ifc16.diff), 32'(last_diff16));
      @(negedge clk);
      waited++;
    end
    chk("ovl busy_cycles", 32'(busy_n), 32'd4);
    chk("ovl done", 32'(ifc16.done), 32'd1);
    chk("ovl diff", 32'(ifc16.diff), 32'h000F);
    chk("ovl bout", 32'(ifc16.bout), 32'd0);
    @(negedge clk);
    chk("ovl done_drop", 32'(ifc16.done), 32'd0);
    chk("ovl no_restart", 32'(ifc16.busy), 32'd0);
    ifc16.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ovl quiet_done", 32'(ifc16.done), 32'd0);
      chk("ovl quiet_busy", 32'(ifc16.busy), 32'd0);
    end
    last_diff16 = 16'h000F;
    last_bout16 = 1'b0;

    // Reset in the middle of RUN
    @(negedge clk);
    ifc16.start = 1'b1; ifc16.a = 16'h4321; ifc16.b = 16'h1111; ifc16.bin = 1'b0;
    @(negedge clk);
    ifc16.start = 1'b0;
    chk("mid busy_before", 32'(ifc16.busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid diff", 32'(ifc16.diff), 32'd0);
    chk("mid bout", 32'(ifc16.bout), 32'd0);
    chk("mid busy", 32'(ifc16.busy), 32'd0);
    chk("mid done", 32'(ifc16.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid no_done", 32'(ifc16.done), 32'd0);
      chk("mid no_busy", 32'(ifc16.busy), 32'd0);
    end
    last_diff16 = '0;
    last_bout16 = 1'b0;
    last_diff4  = '0;
    last_bout4  = 1'b0;
    do_op16(16'h0005, 16'h0003, 1'b0, "post_rst");
    chk("post_rst const", 32'(ifc16.diff), 32'h0002);

    // Randomized 16-bit operations
    for (int i = 0; i < 20; i++) begin
      do_op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "rnd16");
    end

    // N=1 instance
    do_op4(4'b1011, 4'b1010, 1'b0, "w4a");
    chk("w4a const", 32'(ifc4.diff), 32'b0001);
    do_op4(4'b0001, 4'b1010, 1'b1, "w4b");
    chk("w4b const", 32'(ifc4.diff), 32'b0110);
    chk("w4b bout_const", 32'(ifc4.bout), 32'd1);
    for (int i = 0; i < 8; i++) begin
      do_op4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), "rnd4");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
